// File: rtl/mult_share_arbiter_pkg.sv
// Shared constants, FSM state type and helpers for the multiplier-sharing arbiter.
package mult_arb_pkg;

  localparam int unsigned MUL_W    = 32;
  localparam int unsigned MUL_ITER = 32;
  localparam int unsigned RSP_LAT  = 34;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // True when either operand makes the product trivially zero.
  function automatic logic is_zero_pair(input logic [MUL_W-1:0] a, input logic [MUL_W-1:0] b);
    return (a == '0) || (b == '0);
  endfunction

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Requester-side request/response bus of the multiplier-sharing arbiter.
interface mult_share_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 32
);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [2*W-1:0]    rsp_product;
  logic [NREQ-1:0]   rsp_ready;

  // Requesters drive operands and consume responses.
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_product
  );

  // The arbiter accepts requests and steers responses.
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_product
  );

endinterface

// File: rtl/mult_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt_onehot,
  output logic [IDW-1:0]  gnt_idx,
  output logic            any_req
);

  logic [IDW-1:0] idx;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any_req    = 1'b0;
    idx        = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IDW'((32'(ptr) + k) % NREQ);
      if (!any_req && req[idx]) begin
        any_req         = 1'b1;
        gnt_idx         = idx;
        gnt_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one 32x32 signed start/ready multiplier between NREQ requesters with round-robin grant.
// Optional feature macro MULT_ARB_ZERO_BYPASS_EN: zero-operand requests skip the multiplier.
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = MUL_W,
  parameter int unsigned IDW  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  mult_share_arbiter_if.slave rq,
  output logic                mul_start,
  output logic [W-1:0]        mul_a,
  output logic [W-1:0]        mul_b,
  input  logic [2*W-1:0]      mul_product,
  input  logic                mul_ready,
  output logic                busy
);

  localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);

  arb_state_e      state_q;
  logic [IDW-1:0]  rr_ptr_q;
  logic [IDW-1:0]  owner_q;
  logic [W-1:0]    mul_a_q;
  logic [W-1:0]    mul_b_q;
  logic [2*W-1:0]  rsp_product_q;
  logic [NREQ-1:0] rsp_valid_q;
  logic            mul_start_q;
  logic            busy_q;
  logic            bypass_q;

  logic [NREQ-1:0] gnt_onehot;
  logic [IDW-1:0]  gnt_idx;
  logic            any_req;
  logic            accept;
  logic            sel_zero;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;
  logic [IDW-1:0]  ptr_next;
  logic [NREQ-1:0] owner_onehot;
  logic [W-1:0]    a_arr [NREQ];
  logic [W-1:0]    b_arr [NREQ];

  rr_arbiter #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_rr (
    .req       (rq.req_valid),
    .ptr       (rr_ptr_q),
    .gnt_onehot(gnt_onehot),
    .gnt_idx   (gnt_idx),
    .any_req   (any_req)
  );

  // Unpack the flat operand buses so the granted pair can be selected by index.
  for (genvar g = 0; g < NREQ; g++) begin : g_ops
    assign a_arr[g] = rq.req_a[g*W +: W];
    assign b_arr[g] = rq.req_b[g*W +: W];
  end

  assign sel_a        = a_arr[gnt_idx];
  assign sel_b        = b_arr[gnt_idx];
  assign accept       = (state_q == IDLE) && any_req;
  assign ptr_next     = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IDW'(1);
  assign owner_onehot = NREQ'(1) << owner_q;

`ifdef MULT_ARB_ZERO_BYPASS_EN
  assign sel_zero = is_zero_pair(sel_a, sel_b);
`else
  assign sel_zero = 1'b0;
`endif

  // Grant is only offered while idle; it follows req_valid combinationally.
  assign rq.req_ready   = (state_q == IDLE) ? gnt_onehot : '0;
  assign rq.rsp_valid   = rsp_valid_q;
  assign rq.rsp_product = rsp_product_q;
  assign mul_start      = mul_start_q;
  assign mul_a          = mul_a_q;
  assign mul_b          = mul_b_q;
  assign busy           = busy_q;

  // Sequencer. mul_ready is only looked at in WAIT, after our own start has cleared it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      rsp_product_q <= '0;
      rsp_valid_q   <= '0;
      mul_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      bypass_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            mul_a_q     <= sel_a;
            mul_b_q     <= sel_b;
            owner_q     <= gnt_idx;
            rr_ptr_q    <= ptr_next;
            bypass_q    <= sel_zero;
            mul_start_q <= !sel_zero;
            busy_q      <= 1'b1;
            state_q     <= START;
          end
        end
        START: begin
          mul_start_q <= 1'b0;
          // A bypassed request answers from here, one edge after acceptance.
          if (bypass_q) begin
            rsp_product_q <= '0;
            rsp_valid_q   <= owner_onehot;
            state_q       <= RESP;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (mul_ready) begin
            rsp_product_q <= mul_product;
            rsp_valid_q   <= owner_onehot;
            state_q       <= RESP;
          end
        end
        RESP: begin
          if (rq.rsp_ready[owner_q]) begin
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
            bypass_q    <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomized self-checking bench for mult_share_arbiter with a behavioural shift-add multiplier.
module tb_mult_share_arbiter;
  import mult_arb_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 32;
  localparam int          LAT_FULL = int'(RSP_LAT);
`ifdef MULT_ARB_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           mul_start, mul_ready, busy;
  logic [W-1:0]   mul_a, mul_b;
  logic [2*W-1:0] mul_product;

  mult_share_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  mult_share_arbiter #(.NREQ(NREQ), .W(W), .IDW(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rq         (bus),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_product(mul_product),
    .mul_ready  (mul_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Multiplier: loads on start, one signed shift-add step per clock, no reset.
  logic [63:0] m_acc, m_ae;
  logic [31:0] m_b;
  logic [5:0]  m_cnt;
  logic        m_run, m_rdy;
  always_ff @(posedge clk) begin
    if (mul_start) begin
      m_ae  <= {{32{mul_a[31]}}, mul_a};
      m_b   <= mul_b;
      m_acc <= '0;
      m_cnt <= '0;
      m_run <= 1'b1;
      m_rdy <= 1'b0;
    end else if (m_run) begin
      if (m_b[m_cnt[4:0]])
        m_acc <= (m_cnt == 6'(MUL_ITER - 1)) ? m_acc - (m_ae << 31) : m_acc + (m_ae << m_cnt);
      m_cnt <= m_cnt + 6'd1;
      if (m_cnt == 6'(MUL_ITER - 1)) begin
        m_run <= 1'b0;
        m_rdy <= 1'b1;
      end
    end
  end
  assign mul_ready   = m_rdy;
  assign mul_product = m_acc;

  // Requester-side stimulus state and reference model state.
  logic [3:0]  v;
  logic [31:0] op_a [4];
  logic [31:0] op_b [4];
  int          mp;
  int          n_err, n_chk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    bus.req_valid = v;
    bus.req_a     = {op_a[3], op_a[2], op_a[1], op_a[0]};
    bus.req_b     = {op_b[3], op_b[2], op_b[1], op_b[0]};
  endtask

  function automatic int exp_grant(input logic [3:0] vm, input int ptr);
    for (int k = 0; k < 4; k++)
      if (vm[(ptr + k) % 4]) return (ptr + k) % 4;
    return 0;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    v = '0;
    drive();
    mp = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One full transaction: grant, latency, start count, product, optional backpressure, return to idle.
  task automatic do_txn(input bit keep, input int hold, output int g);
    int          wait_cyc, lat, starts, eg, exp_lat, exp_starts;
    bit          zero, stable;
    logic [63:0] ep;
    g = -1;
    #1;
    wait_cyc = 0;
    while (bus.req_ready == '0 && wait_cyc < 50) begin
      @(negedge clk);
      #1;
      wait_cyc++;
    end
    eg = exp_grant(v, mp);
    if (bus.req_ready == '0) begin
      check("grant_timeout", 64'(bus.req_ready), 64'(1) << eg);
      return;
    end
    check("grant", 64'(bus.req_ready), 64'(1) << eg);
    g          = eg;
    zero       = (op_a[g] == '0) || (op_b[g] == '0);
    ep         = 64'($signed(op_a[g])) * 64'($signed(op_b[g]));
    exp_lat    = (BYP && zero) ? 1 : LAT_FULL;
    exp_starts = (BYP && zero) ? 0 : 1;
    @(posedge clk);
    @(negedge clk);
    mp = (g + 1) % 4;
    if (!keep) v[g] = 1'b0;
    if (hold > 0) bus.rsp_ready[g] = 1'b0;
    drive();
    check("mul_a", 64'(mul_a), 64'(op_a[g]));
    check("mul_b", 64'(mul_b), 64'(op_b[g]));
    starts = mul_start ? 1 : 0;
    lat = 0;
    while (bus.rsp_valid == '0 && lat < 60) begin
      @(negedge clk);
      lat++;
      if (mul_start) starts++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("start_pulses", 64'(starts), 64'(exp_starts));
    check("rsp_onehot", 64'(bus.rsp_valid), 64'(1) << g);
    check("product", bus.rsp_product, ep);
    if (hold > 0) begin
      stable = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (bus.rsp_valid != 4'(64'(1) << g) || bus.rsp_product != ep ||
            bus.req_ready != '0 || !busy) stable = 1'b0;
      end
      check("hold_stable", 64'(stable), 64'(1));
      bus.rsp_ready[g] = 1'b1;
    end
    @(negedge clk);
    check("back_idle", 64'({busy, bus.rsp_valid}), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    n_err = 0;
    n_chk = 0;
    for (int i = 0; i < 4; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    bus.rsp_ready = '1;
    do_reset();

    // Reset state.
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_req_ready", 64'(bus.req_ready), 64'(0));
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("rst_mul_start", 64'(mul_start), 64'(0));
    check("rst_mul_a", 64'(mul_a), 64'(0));
    check("rst_mul_b", 64'(mul_b), 64'(0));
    check("rst_product", bus.rsp_product, 64'(0));

    // Single request 7 * -3.
    op_a[0] = 32'd7;
    op_b[0] = 32'hFFFF_FFFD;
    v = 4'b0001;
    drive();
    do_txn(1'b0, 0, g);

    // All four from reset: served 0,1,2,3.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      op_a[i] = 32'(i + 1);
      op_b[i] = 32'd10;
    end
    v = 4'hF;
    drive();
    repeat (4) do_txn(1'b0, 0, g);

    // Move the pointer to 2, then req1 and req3 held continuously.
    op_a[1] = 32'd3;
    op_b[1] = 32'hFFFF_FFFB;
    v = 4'b0010;
    drive();
    do_txn(1'b0, 0, g);
    op_a[3] = 32'd1000;
    op_b[3] = 32'd77;
    v = 4'b1010;
    drive();
    repeat (4) do_txn(1'b1, 0, g);
    v = '0;
    drive();

    // Backpressure on requester 2 with others waiting.
    op_a[0] = 32'd11;  op_b[0] = 32'd13;
    op_a[2] = 32'hFFFF_FF00; op_b[2] = 32'd5;
    op_a[3] = 32'd123; op_b[3] = 32'hFFFF_FFFF;
    v = 4'b1101;
    drive();
    do_txn(1'b0, 20, g);
    repeat (2) do_txn(1'b0, 0, g);

    // A request withdrawn before grant leaves the arbiter idle.
    #1;
    v = 4'b0010;
    drive();
    #1;
    check("withdraw_grant", 64'(bus.req_ready), 64'(4'b0010));
    v = '0;
    drive();
    #1;
    check("withdraw_none", 64'(bus.req_ready), 64'(0));
    @(negedge clk);
    check("withdraw_idle", 64'(busy), 64'(0));

    // Reset in the middle of an operation, then a clean -1 * -1.
    op_a[0] = $urandom;
    op_b[0] = $urandom | 32'd1;
    v = 4'b0001;
    drive();
    @(posedge clk);
    repeat (14) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("abort_mul_start", 64'(mul_start), 64'(0));
    v = '0;
    drive();
    mp = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_no_rsp", 64'({busy, bus.rsp_valid}), 64'(0));
    op_a[0] = 32'hFFFF_FFFF;
    op_b[0] = 32'hFFFF_FFFF;
    v = 4'b0001;
    drive();
    do_txn(1'b0, 0, g);

    // Zero operand, and the most negative square.
    op_a[0] = 32'd0;
    op_b[0] = 32'd12345;
    v = 4'b0001;
    drive();
    do_txn(1'b0, 0, g);
    op_a[2] = 32'h8000_0000;
    op_b[2] = 32'h8000_0000;
    v = 4'b0100;
    drive();
    do_txn(1'b0, 0, g);

    // Random traffic against the reference model.
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < 4; i++) begin
        if (!v[i] && $urandom_range(0, 1) == 1) begin
          v[i] = 1'b1;
          op_a[i] = pick();
          op_b[i] = pick();
        end
      end
      if (v == '0) begin
        v[t % 4] = 1'b1;
        op_a[t % 4] = pick();
        op_b[t % 4] = pick();
      end
      drive();
      do_txn($urandom_range(0, 3) == 0, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, g);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
